io_bridge: RTL

Sits between the CPU data-memory port and the memory-mapped I/O devices, including the simulation trickbox (time and putc ports). It decodes the I/O address window and posts stores into a small write FIFO that drains one entry per cycle to the device port. Loads are ordered behind pending stores, issued to the device, and bounded by a timeout. Non-I/O accesses are flagged as misses so the upstream mux routes them to RAM.

---
 rtl/io_bridge_pkg.sv | 25 ++
 rtl/io_wr_fifo.sv | 55 +++++
 rtl/io_bridge.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/io_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_bridge_pkg
// Brief    : Shared types for the CPU-to-MMIO bridge (FSM state, FIFO entry).
// Revision : 1.0
// ============================================================================
package io_bridge_pkg;

  // Widest address the posted-write entry can carry.
  localparam int c_ENTRY_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_DRAIN  = 2'd1,
    RD_ACCESS = 2'd2,
    RD_RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [c_ENTRY_ADDR_W-1:0] addr;
    logic [31:0]               data;
  } wr_entry_t;

endpackage
`default_nettype wire

// File: rtl/io_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : io_wr_fifo
// Brief    : Synchronous posted-write FIFO; extra pointer bit separates full from empty.
// Revision : 1.0
// ============================================================================
module io_wr_fifo
  import io_bridge_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wr_entry_t
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_PTR_W = c_IDX_W + 1;

  entry_t             r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic               w_push;
  logic               w_pop;

  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[c_IDX_W] != r_rd_ptr[c_IDX_W]) &&
                  (r_wr_ptr[c_IDX_W-1:0] == r_rd_ptr[c_IDX_W-1:0]);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign head   = r_mem[r_rd_ptr[c_IDX_W-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[c_IDX_W-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : io_bridge
// Brief    : Decodes the I/O window, posts stores through a FIFO, orders loads behind them.
// Revision : 1.0
// ============================================================================
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 32'hAAAA0000,
  parameter logic [ADDR_WIDTH-1:0] IO_MASK    = 32'hFFFF0000,
  parameter int                    FIFO_DEPTH = 4,
  parameter int                    RD_TIMEOUT = 16,
  parameter logic [31:0]           ERR_RDATA  = 32'hDEADBEEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_io_hit,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_err,
  output logic [ADDR_WIDTH-1:0] dev_addr,
  output logic                  dev_read,
  output logic                  dev_write,
  output logic [31:0]           dev_wdata,
  input  logic [31:0]           dev_rdata,
  input  logic                  dev_taken,
  output logic [15:0]           wr_drop_count
);

  localparam int                 c_TMR_W    = $clog2(RD_TIMEOUT) + 1;
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(RD_TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [c_TMR_W-1:0]    r_timer;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [15:0]           r_drop_count;

  logic      w_io;
  logic      w_store;
  logic      w_load;
  logic      w_push;
  logic      w_drain;
  logic      w_latch;
  logic      w_capture;
  logic      w_timeout;
  logic      w_fifo_full;
  logic      w_fifo_empty;
  wr_entry_t w_push_entry;
  wr_entry_t w_head;

  assign w_io    = cpu_req & ((cpu_addr & IO_MASK) == IO_BASE);
  assign w_store = w_io & cpu_we;
  assign w_load  = w_io & ~cpu_we;
  assign w_push  = w_store & (r_state == IDLE) & ~w_fifo_full;
  // FIFO is always empty in RD_ACCESS, so read and write strobes never overlap.
  assign w_drain = ~w_fifo_empty & (r_state != RD_ACCESS);

  assign w_push_entry.addr = c_ENTRY_ADDR_W'(cpu_addr);
  assign w_push_entry.data = cpu_wdata;

  io_wr_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (wr_entry_t)
  ) u_wr_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_drain),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .head      (w_head)
  );

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    dev_read     = 1'b0;
    cpu_rvalid   = 1'b0;
    cpu_stall    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_latch      = 1'b1;
          w_state_next = w_fifo_empty ? RD_ACCESS : RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (w_fifo_empty) w_state_next = RD_ACCESS;
      end
      RD_ACCESS: begin
        dev_read = 1'b1;
        if (dev_taken) begin
          w_capture    = 1'b1;
          w_state_next = RD_RESP;
        end else if (r_timer == c_TMR_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = RD_RESP;
        end
      end
      RD_RESP: begin
        cpu_rvalid   = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (w_store)     cpu_stall = (r_state != IDLE) | w_fifo_full;
    else if (w_load) cpu_stall = (r_state != RD_RESP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_rd_addr    <= '0;
      r_timer      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= (r_state == RD_ACCESS) ? r_timer + 1'b1 : '0;
      if (w_latch) r_rd_addr <= cpu_addr;
      if (w_capture) begin
        r_rdata <= dev_rdata;
        r_err   <= 1'b0;
      end else if (w_timeout) begin
        r_rdata <= ERR_RDATA;
        r_err   <= 1'b1;
      end
      if (w_drain && !dev_taken && r_drop_count != 16'hFFFF)
        r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign cpu_io_hit    = w_io;
  assign cpu_rdata     = r_rdata;
  assign cpu_err       = cpu_rvalid & r_err;
  assign dev_write     = w_drain;
  assign dev_wdata     = w_drain ? w_head.data : '0;
  assign dev_addr      = dev_read ? r_rd_addr
                       : w_drain  ? ADDR_WIDTH'(w_head.addr)
                       :            '0;
  assign wr_drop_count = r_drop_count;

endmodule
`default_nettype wire
